// File: rtl/frame_sequencer.sv
// frame_sequencer: buffers an 11-bit sample stream, tags each sample with a
// slot index derived from start-of-frame markers, and holds every
// (data, dataChange) pair long enough for a bank that samples once per 11 clocks.
module frame_sequencer #(
  parameter int DATA_W      = 11,
  parameter int IDX_W       = 6,
  parameter int HOLD_CYCLES = 12,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data,
  output logic [IDX_W-1:0]  dataChange,
  output logic              busy,
  output logic              frame_done,
  output logic              sof_err
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [IDX_W-1:0]  LAST_SLOT  = '1;
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [HCNT_W-1:0] HOLD_LOAD  = HCNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state, next_state;

  logic [DATA_W:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                fifo_full, fifo_empty;
  logic                push, pop;

  logic [HCNT_W-1:0]   hold_cnt;
  logic [IDX_W-1:0]    last_idx;
  logic                sof_seen;

  logic [DATA_W:0]     head;
  logic                head_sof;
  logic [DATA_W-1:0]   head_data;
  logic [IDX_W-1:0]    next_idx;
  logic                err_now;
  logic                hold_done;

  // Full/empty come from the registered count only, so a pop in the same
  // cycle never opens the door for a push into a full buffer.
  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  assign busy       = (state == HOLD);
  assign hold_done  = (state == HOLD) && (hold_cnt == '0);

  assign head      = mem[rd_ptr];
  assign head_sof  = head[DATA_W];
  assign head_data = head[DATA_W-1:0];
  assign next_idx  = head_sof ? '0 : last_idx + IDX_W'(1);
  assign err_now   = head_sof ? (last_idx != LAST_SLOT)
                              : ((last_idx == LAST_SLOT) && sof_seen);

  // Storage array: written on accepted pushes, contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_sof, in_data};
    end
  end

  // Buffer pointers and occupancy; reset drops every buffered entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and pop decision; a pop at the end of a window reloads gaplessly.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          if (!fifo_empty) pop = 1'b1;
          else             next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output pair, slot tracking, hold timer and framing flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data       <= '0;
      dataChange <= '0;
      last_idx   <= LAST_SLOT;
      sof_seen   <= 1'b0;
      sof_err    <= 1'b0;
      hold_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= hold_done && (dataChange == LAST_SLOT);
      if (pop) begin
        data       <= head_data;
        dataChange <= next_idx;
        last_idx   <= next_idx;
        hold_cnt   <= HOLD_LOAD;
        if (head_sof) sof_seen <= 1'b1;
        if (err_now)  sof_err  <= 1'b1;
      end else if ((state == HOLD) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - HCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed testbench for frame_sequencer with a passive window monitor and
// a model of the downstream bank that samples once every 11 clocks.
module tb_frame_sequencer;

  localparam int DATA_W = 11;
  localparam int IDX_W  = 6;
  localparam int HOLD   = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_sof = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] data;
  logic [IDX_W-1:0]  dataChange;
  logic              busy;
  logic              frame_done;
  logic              sof_err;

  int checks = 0;
  int errors = 0;

  logic [16:0]       seen_q[$];
  logic [DATA_W-1:0] bank [64];
  int                frame_done_cnt = 0;
  int                busy_rises = 0;
  int                win_cnt = 0;
  logic              prev_busy = 1'b0;
  int                phase = 0;

  frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sof(in_sof),
    .in_valid(in_valid), .in_ready(in_ready), .data(data),
    .dataChange(dataChange), .busy(busy), .frame_done(frame_done),
    .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  // Monitor: records each hold window, checks its length, models the bank.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      phase = (phase == 10) ? 0 : phase + 1;
      if (!rst_n) begin
        win_cnt   = 0;
        prev_busy = 1'b0;
      end else begin
        if (frame_done) frame_done_cnt++;
        if (busy) begin
          if (!prev_busy) busy_rises++;
          if (!prev_busy || win_cnt == HOLD) begin
            seen_q.push_back({dataChange, data});
            win_cnt = 1;
          end else begin
            win_cnt++;
          end
          if (phase == 0) bank[dataChange] = data;
        end else if (prev_busy) begin
          checks++;
          if (win_cnt !== HOLD) begin
            errors++;
            $display("[TB] FAIL window_len got %0d expected %0d", win_cnt, HOLD);
          end
          win_cnt = 0;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic clear_records();
    seen_q.delete();
    frame_done_cnt = 0;
    busy_rises = 0;
    for (int i = 0; i < 64; i++) bank[i] = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_records();
  endtask

  // Drives one sample at a negedge and returns at the negedge after acceptance.
  task automatic push(input logic [DATA_W-1:0] d, input logic s, output int waited);
    logic acc;
    waited = 0;
    in_data = d;
    in_sof = s;
    in_valid = 1'b1;
    forever begin
      acc = in_ready;
      @(negedge clk);
      if (acc) break;
      waited++;
      if (waited > 500) begin
        checks++;
        errors++;
        $display("[TB] FAIL push_timeout got no in_ready expected accept");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout got busy expected idle");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic push_frame(input int n, input logic first_sof);
    int w;
    for (int i = 0; i < n; i++) push(DATA_W'(i * 3), (i == 0) && first_sof, w);
  endtask

  task automatic test_reset();
    int w;
    int n;
    repeat (3) @(negedge clk);
    checks += 6;
    if (data !== '0)       begin errors++; $display("[TB] FAIL rst_data got %h expected 0", data); end
    if (dataChange !== '0) begin errors++; $display("[TB] FAIL rst_idx got %0d expected 0", dataChange); end
    if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL rst_busy got %b expected 0", busy); end
    if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_frame_done got %b expected 0", frame_done); end
    if (sof_err !== 1'b0)  begin errors++; $display("[TB] FAIL rst_sof_err got %b expected 0", sof_err); end
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready got %b expected 1", in_ready); end
    rst_n = 1'b1;
    clear_records();
    push(11'h155, 1'b1, w);
    checks += 2;
    if (data !== '0)       begin errors++; $display("[TB] FAIL pre_pop_data got %h expected 0", data); end
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL pre_pop_ready got %b expected 1", in_ready); end
    @(negedge clk);
    checks += 3;
    if (data !== 11'h155)  begin errors++; $display("[TB] FAIL first_data got %h expected 155", data); end
    if (dataChange !== '0) begin errors++; $display("[TB] FAIL first_idx got %0d expected 0", dataChange); end
    if (busy !== 1'b1)     begin errors++; $display("[TB] FAIL first_busy got %b expected 1", busy); end
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== HOLD) begin errors++; $display("[TB] FAIL first_hold_len got %0d expected %0d", n, HOLD); end
  endtask

  task automatic test_full_frame();
    int bad_seq = 0;
    int bad_bank = 0;
    apply_reset();
    push_frame(64, 1'b1);
    wait_idle();
    checks++;
    if (seen_q.size() !== 64) begin errors++; $display("[TB] FAIL frame_count got %0d expected 64", seen_q.size()); end
    for (int i = 0; i < seen_q.size() && i < 64; i++)
      if (seen_q[i] !== {IDX_W'(i), DATA_W'(i * 3)}) bad_seq++;
    for (int i = 0; i < 64; i++)
      if (bank[i] !== DATA_W'(i * 3)) bad_bank++;
    checks += 5;
    if (bad_seq !== 0)        begin errors++; $display("[TB] FAIL frame_sequence got %0d bad expected 0", bad_seq); end
    if (bad_bank !== 0)       begin errors++; $display("[TB] FAIL bank_capture got %0d bad expected 0", bad_bank); end
    if (frame_done_cnt !== 1) begin errors++; $display("[TB] FAIL frame_done_count got %0d expected 1", frame_done_cnt); end
    if (busy_rises !== 1)     begin errors++; $display("[TB] FAIL frame_gapless got %0d rises expected 1", busy_rises); end
    if (sof_err !== 1'b0)     begin errors++; $display("[TB] FAIL frame_sof_err got %b expected 0", sof_err); end
  endtask

  task automatic test_backpressure();
    int w;
    int wsum = 0;
    int w5;
    int w6;
    int bad = 0;
    apply_reset();
    push(11'h100, 1'b1, w);
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      push(DATA_W'(11'h100 + i), 1'b0, w);
      wsum += w;
    end
    checks += 2;
    if (wsum !== 0)        begin errors++; $display("[TB] FAIL bp_first4_wait got %0d expected 0", wsum); end
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_ready got %b expected 0", in_ready); end
    push(11'h105, 1'b0, w5);
    push(11'h106, 1'b0, w6);
    checks += 2;
    if (w5 <= 0)        begin errors++; $display("[TB] FAIL bp_fifth_wait got %0d expected >0", w5); end
    if (w6 !== HOLD - 1) begin errors++; $display("[TB] FAIL bp_sixth_wait got %0d expected %0d", w6, HOLD - 1); end
    wait_idle();
    for (int i = 0; i < seen_q.size() && i < 7; i++)
      if (seen_q[i] !== {IDX_W'(i), DATA_W'(11'h100 + i)}) bad++;
    checks += 2;
    if (seen_q.size() !== 7) begin errors++; $display("[TB] FAIL bp_count got %0d expected 7", seen_q.size()); end
    if (bad !== 0)           begin errors++; $display("[TB] FAIL bp_contents got %0d bad expected 0", bad); end
  endtask

  task automatic test_short_frame();
    int w;
    apply_reset();
    push(11'h000, 1'b1, w);
    for (int i = 1; i <= 9; i++) push(DATA_W'(i), 1'b0, w);
    wait_idle();
    checks++;
    if (sof_err !== 1'b0) begin errors++; $display("[TB] FAIL short_pre_err got %b expected 0", sof_err); end
    push(11'h0AA, 1'b1, w);
    wait_idle();
    checks += 3;
    if (seen_q.size() !== 11) begin errors++; $display("[TB] FAIL short_count got %0d expected 11", seen_q.size()); end
    if (seen_q[seen_q.size() - 1] !== {IDX_W'(0), 11'h0AA})
      begin errors++; $display("[TB] FAIL short_sof_slot got %h expected %h", seen_q[seen_q.size() - 1], {IDX_W'(0), 11'h0AA}); end
    if (sof_err !== 1'b1) begin errors++; $display("[TB] FAIL short_err got %b expected 1", sof_err); end
    clear_records();
    push_frame(64, 1'b1);
    wait_idle();
    checks += 2;
    if (sof_err !== 1'b1)     begin errors++; $display("[TB] FAIL short_sticky got %b expected 1", sof_err); end
    if (seen_q.size() !== 64) begin errors++; $display("[TB] FAIL short_clean_count got %0d expected 64", seen_q.size()); end
  endtask

  task automatic test_wrap_no_sof();
    int w;
    int bad = 0;
    apply_reset();
    for (int i = 0; i < 65; i++) push(DATA_W'(i), 1'b0, w);
    wait_idle();
    for (int i = 0; i < seen_q.size() && i < 65; i++)
      if (seen_q[i] !== {IDX_W'(i % 64), DATA_W'(i)}) bad++;
    checks += 3;
    if (seen_q.size() !== 65) begin errors++; $display("[TB] FAIL wrap_count got %0d expected 65", seen_q.size()); end
    if (bad !== 0)            begin errors++; $display("[TB] FAIL wrap_slots got %0d bad expected 0", bad); end
    if (sof_err !== 1'b0)     begin errors++; $display("[TB] FAIL wrap_err got %b expected 0", sof_err); end
  endtask

  task automatic test_reset_mid_hold();
    int w;
    apply_reset();
    push(11'h3FF, 1'b1, w);
    push(11'h011, 1'b0, w);
    push(11'h022, 1'b0, w);
    push(11'h033, 1'b0, w);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks += 4;
    if (data !== '0)       begin errors++; $display("[TB] FAIL mid_rst_data got %h expected 0", data); end
    if (dataChange !== '0) begin errors++; $display("[TB] FAIL mid_rst_idx got %0d expected 0", dataChange); end
    if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL mid_rst_busy got %b expected 0", busy); end
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_ready got %b expected 1", in_ready); end
    rst_n = 1'b1;
    clear_records();
    repeat (40) @(negedge clk);
    checks += 2;
    if (seen_q.size() !== 0) begin errors++; $display("[TB] FAIL mid_rst_leak got %0d expected 0", seen_q.size()); end
    if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL mid_rst_idle got %b expected 0", busy); end
  endtask

  initial begin
    $display("[TB] frame_sequencer directed tests start");
    test_reset();
    test_full_frame();
    test_backpressure();
    test_short_frame();
    test_wrap_no_sof();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
